// File: rtl/sddev_cmd.sv
// sddev_cmd: card-side SD CMD-line engine. Deserializes host commands with CRC7
// checking and serializes 48-bit or 136-bit R2 responses after the N_CR gap.
module sddev_cmd #(
    parameter int NCR = 2
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_ckstb,
    input  logic         i_cmd,
    output logic         o_cmd_en,
    output logic         o_cmd,
    output logic         o_req_valid,
    output logic         o_req_err,
    output logic [5:0]   o_req_id,
    output logic [31:0]  o_req_arg,
    input  logic         i_rsp_valid,
    output logic         o_rsp_ready,
    input  logic         i_rsp_type,
    input  logic [5:0]   i_rsp_id,
    input  logic [119:0] i_rsp_data,
    output logic         o_busy
);
    typedef enum logic [2:0] {IDLE, RX, SKIP, WAIT, GAP, TX} state_t;

    state_t       state, state_nxt;
    logic [7:0]   bit_cnt;
    logic [44:0]  rx_sr;
    logic [6:0]   crc;
    logic [6:0]   gap_cnt;
    logic [135:0] tx_sr;
    logic         rsp_type;
    logic         frame_err, gap_done, accept, tx_fire, tx_bit;
    logic [7:0]   crc_from, crc_at, last_bit;

    function automatic logic [6:0] crc7_next(input logic [6:0] c, input logic d);
        logic fb;
        fb = d ^ c[6];
        return {c[5:3], c[2] ^ fb, c[1:0], fb};
    endfunction

    // rx_sr holds frame bits 45..1 when the end bit is on the line
    always_comb begin
        frame_err = (rx_sr[6:0] != crc) || !i_cmd;
        gap_done  = gap_cnt >= 7'(NCR - 1);
        accept    = (state == WAIT) && i_rsp_valid;
        crc_from  = rsp_type ? 8'd8   : 8'd0;
        crc_at    = rsp_type ? 8'd128 : 8'd40;
        last_bit  = rsp_type ? 8'd135 : 8'd47;
        tx_fire   = i_ckstb && (((state == GAP) && gap_done) ||
                                ((state == TX) && (bit_cnt <= last_bit)));
        if (bit_cnt < crc_at)
            tx_bit = tx_sr[135];
        else if (bit_cnt < last_bit)
            tx_bit = crc[6];
        else
            tx_bit = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (i_ckstb && !i_cmd) state_nxt = RX;
            RX: if (i_ckstb) begin
                if (bit_cnt == 8'd1 && !i_cmd)
                    state_nxt = SKIP;
                else if (bit_cnt == 8'd47)
                    state_nxt = frame_err ? IDLE : WAIT;
            end
            SKIP: if (i_ckstb && bit_cnt == 8'd47) state_nxt = IDLE;
            WAIT: begin
                if (i_rsp_valid)
                    state_nxt = GAP;
                else if (i_ckstb && !i_cmd)
                    state_nxt = RX;
            end
            GAP: if (i_ckstb && gap_done) state_nxt = TX;
            TX: if (i_ckstb && bit_cnt > last_bit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_busy      = state != IDLE;
        o_rsp_ready = state == WAIT;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            bit_cnt     <= '0;
            rx_sr       <= '0;
            crc         <= '0;
            gap_cnt     <= '0;
            tx_sr       <= '0;
            rsp_type    <= 1'b0;
            o_cmd_en    <= 1'b0;
            o_cmd       <= 1'b1;
            o_req_valid <= 1'b0;
            o_req_err   <= 1'b0;
            o_req_id    <= '0;
            o_req_arg   <= '0;
        end else begin
            o_req_valid <= 1'b0;
            o_req_err   <= 1'b0;
            case (state)
                IDLE: if (i_ckstb && !i_cmd) begin
                    bit_cnt <= 8'd1;
                    rx_sr   <= '0;
                    crc     <= '0;
                end
                RX: if (i_ckstb) begin
                    rx_sr   <= {rx_sr[43:0], i_cmd};
                    bit_cnt <= bit_cnt + 8'd1;
                    if (bit_cnt < 8'd40)
                        crc <= crc7_next(crc, i_cmd);
                    if (bit_cnt == 8'd47) begin
                        o_req_valid <= 1'b1;
                        o_req_err   <= frame_err;
                        o_req_id    <= rx_sr[44:39];
                        o_req_arg   <= rx_sr[38:7];
                        gap_cnt     <= '0;
                    end
                end
                SKIP: if (i_ckstb) bit_cnt <= bit_cnt + 8'd1;
                WAIT: begin
                    if (i_ckstb && gap_cnt != 7'h7F)
                        gap_cnt <= gap_cnt + 7'd1;
                    // an offered response wins over a competing start bit
                    if (accept) begin
                        rsp_type <= i_rsp_type;
                        bit_cnt  <= '0;
                        crc      <= '0;
                        tx_sr    <= i_rsp_type ? {2'b00, 6'h3F, i_rsp_data, 8'h00}
                                               : {2'b00, i_rsp_id, i_rsp_data[31:0], 96'b0};
                    end else if (i_ckstb && !i_cmd) begin
                        bit_cnt <= 8'd1;
                        rx_sr   <= '0;
                        crc     <= '0;
                    end
                end
                GAP: if (i_ckstb && gap_cnt != 7'h7F) gap_cnt <= gap_cnt + 7'd1;
                TX: if (i_ckstb && bit_cnt > last_bit) begin
                    o_cmd_en <= 1'b0;
                    o_cmd    <= 1'b1;
                end
                default: ;
            endcase

            // payload bits shift out and feed the CRC, then the CRC itself shifts out
            if (tx_fire) begin
                o_cmd_en <= 1'b1;
                o_cmd    <= tx_bit;
                bit_cnt  <= bit_cnt + 8'd1;
                if (bit_cnt < crc_at) begin
                    tx_sr <= {tx_sr[134:0], 1'b0};
                    if (bit_cnt >= crc_from)
                        crc <= crc7_next(crc, tx_bit);
                end else if (bit_cnt < last_bit) begin
                    crc <= {crc[5:0], 1'b0};
                end
            end
        end
    end
endmodule

// File: tb/tb_sddev_cmd.sv
// Bench for sddev_cmd: directed and randomized command/response traffic checked
// against a frame model that derives CRC7 by polynomial long division.
module tb_sddev_cmd;
    localparam int NCR = 2;

    logic         i_clk = 1'b0;
    logic         i_reset_n = 1'b0;
    logic         i_ckstb = 1'b0;
    logic         i_cmd = 1'b1;
    logic         o_cmd_en, o_cmd, o_req_valid, o_req_err;
    logic [5:0]   o_req_id;
    logic [31:0]  o_req_arg;
    logic         i_rsp_valid = 1'b0;
    logic         o_rsp_ready;
    logic         i_rsp_type = 1'b0;
    logic [5:0]   i_rsp_id = '0;
    logic [119:0] i_rsp_data = '0;
    logic         o_busy;

    int checks = 0;
    int errors = 0;
    int div = 1;
    int n_valid = 0;
    logic s_en, s_cmd, s_busy, s_ready, first_ready;
    logic v_err;
    logic [5:0] v_id;
    logic [31:0] v_arg;

    logic [47:0]  rf;
    logic [5:0]   rid;
    logic [31:0]  rarg;
    logic [119:0] rdata;
    int flaw, idx;

    sddev_cmd #(.NCR(NCR)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_ckstb(i_ckstb), .i_cmd(i_cmd),
        .o_cmd_en(o_cmd_en), .o_cmd(o_cmd), .o_req_valid(o_req_valid), .o_req_err(o_req_err),
        .o_req_id(o_req_id), .o_req_arg(o_req_arg), .i_rsp_valid(i_rsp_valid),
        .o_rsp_ready(o_rsp_ready), .i_rsp_type(i_rsp_type), .i_rsp_id(i_rsp_id),
        .i_rsp_data(i_rsp_data), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    // remainder of M(x)*x^7 divided by x^7+x^3+1; message occupies m[len-1:0], MSB first
    function automatic logic [6:0] crc7_div(input logic [127:0] m, input int len);
        logic [134:0] r;
        r = {7'b0, m} << 7;
        for (int i = len + 6; i >= 7; i--)
            if (r[i]) begin
                r[i]   = 1'b0;
                r[i-4] = ~r[i-4];
                r[i-7] = ~r[i-7];
            end
        return r[6:0];
    endfunction

    function automatic logic [47:0] make_cmd(input logic [5:0] id, input logic [31:0] arg);
        logic [39:0] m;
        m = {2'b01, id, arg};
        return {m, crc7_div(128'(m), 40), 1'b1};
    endfunction

    function automatic logic [135:0] build_rsp(input logic typ, input logic [5:0] id,
                                               input logic [119:0] data);
        logic [39:0] m;
        if (typ)
            return {2'b00, 6'h3F, data, crc7_div(128'(data), 120), 1'b1};
        m = {2'b00, id, data[31:0]};
        return 136'({m, crc7_div(128'(m), 40), 1'b1});
    endfunction

    task automatic check_output(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one SD clock period: strobe with the given CMD level, sample just after the edge
    task automatic strobe(input logic b);
        i_cmd   = b;
        i_ckstb = 1'b1;
        @(negedge i_clk);
        i_ckstb     = 1'b0;
        i_rsp_valid = 1'b0;
        i_cmd       = 1'b1;
        s_en    = o_cmd_en;
        s_cmd   = o_cmd;
        s_busy  = o_busy;
        s_ready = o_rsp_ready;
        if (o_req_valid) begin
            n_valid++;
            v_err = o_req_err;
            v_id  = o_req_id;
            v_arg = o_req_arg;
        end
        for (int k = 1; k < div; k++) @(negedge i_clk);
    endtask

    task automatic send_frame(input logic [47:0] f, input int nbits);
        n_valid = 0;
        for (int i = 47; i > 47 - nbits; i--) begin
            strobe(f[i]);
            if (i == 47) first_ready = s_ready;
        end
    endtask

    task automatic check_req(input string tag, input logic exp_err, input logic [5:0] id,
                             input logic [31:0] arg);
        check_output({tag, "_valid"}, 136'(n_valid), 136'(1));
        check_output({tag, "_err"}, 136'(v_err), 136'(exp_err));
        check_output({tag, "_ready"}, 136'(s_ready), 136'(!exp_err));
        if (!exp_err) begin
            check_output({tag, "_id"}, 136'(v_id), 136'(id));
            check_output({tag, "_arg"}, 136'(v_arg), 136'(arg));
        end
    endtask

    task automatic reset_check(input string tag);
        i_reset_n = 1'b0;
        @(negedge i_clk);
        check_output({tag, "_cmd_en"}, 136'(o_cmd_en), 136'(0));
        check_output({tag, "_cmd"}, 136'(o_cmd), 136'(1));
        check_output({tag, "_req_valid"}, 136'(o_req_valid), 136'(0));
        check_output({tag, "_req_err"}, 136'(o_req_err), 136'(0));
        check_output({tag, "_req_id"}, 136'(o_req_id), 136'(0));
        check_output({tag, "_req_arg"}, 136'(o_req_arg), 136'(0));
        check_output({tag, "_rsp_ready"}, 136'(o_rsp_ready), 136'(0));
        check_output({tag, "_busy"}, 136'(o_busy), 136'(0));
        i_reset_n = 1'b1;
    endtask

    task automatic idle_probe(input int n, input string tag);
        int bad;
        bad = 0;
        for (int j = 0; j < n; j++) begin
            i_rsp_valid = 1'b1;
            if (o_rsp_ready || o_cmd_en) bad++;
            strobe(1'b1);
            if (s_en || s_ready) bad++;
        end
        check_output({tag, "_silent"}, 136'(bad), 136'(0));
    endtask

    // pre: idle strobes spent in WAIT before offering; with_start: offer on a start-bit strobe
    task automatic respond(input int pre, input bit with_start, input logic typ,
                           input logic [5:0] id, input logic [119:0] data,
                           input int abort_at, input string tag);
        logic [135:0] got, exp;
        int k, first, nb, exp_first;
        bit done;
        k = 0; first = -1; nb = 0; got = '0; done = 1'b0;
        for (int j = 0; j < pre; j++) begin
            strobe(1'b1);
            k++;
        end
        check_output({tag, "_ready"}, 136'(o_rsp_ready), 136'(1));
        i_rsp_valid = 1'b1;
        i_rsp_type  = typ;
        i_rsp_id    = id;
        i_rsp_data  = data;
        if (with_start) begin
            strobe(1'b0);
            k++;
        end else begin
            @(negedge i_clk);
            i_rsp_valid = 1'b0;
        end
        exp_first = (k + 1 > NCR) ? k + 1 : NCR;
        for (int j = 0; j < 400 && !done; j++) begin
            strobe(1'b1);
            k++;
            if (s_en) begin
                if (first < 0) first = k;
                got = {got[134:0], s_cmd};
                nb++;
                if (nb == abort_at) return;
            end else if (first >= 0) begin
                done = 1'b1;
            end
        end
        exp = build_rsp(typ, id, data);
        check_output({tag, "_done"}, 136'(done), 136'(1));
        check_output({tag, "_first"}, 136'(first), 136'(exp_first));
        check_output({tag, "_len"}, 136'(nb), typ ? 136'(136) : 136'(48));
        check_output({tag, "_bits"}, got, exp);
        check_output({tag, "_release_cmd"}, 136'(s_cmd), 136'(1));
        if (typ) begin
            check_output({tag, "_hdr"}, 136'(got[135:128]), 136'(8'h3F));
            check_output({tag, "_end"}, 136'(got[0]), 136'(1));
        end
    endtask

    initial begin
        repeat (3) @(negedge i_clk);
        reset_check("por");
        div = 1;

        send_frame(48'h400000000095, 48);
        check_req("cmd0", 1'b0, 6'd0, 32'h0);

        send_frame(48'h48000001AA87, 48);
        check_req("cmd8", 1'b0, 6'd8, 32'h1AA);
        respond(0, 1'b0, 1'b0, 6'd8, 120'h1AA, -1, "r1");

        send_frame(48'h48000001AA85, 48);
        check_req("badcrc", 1'b1, 6'd8, 32'h1AA);
        idle_probe(8, "badcrc");

        send_frame(48'h48000001AA86, 48);
        check_req("badend", 1'b1, 6'd8, 32'h1AA);
        idle_probe(8, "badend");

        // another card's response on the line must be skipped silently
        rf = {2'b00, 6'h3F, 32'h00000900, 7'h55, 1'b1};
        n_valid = 0;
        for (int i = 47; i >= 1; i--) strobe(rf[i]);
        check_output("skip_busy", 136'(s_busy), 136'(1));
        strobe(rf[0]);
        check_output("skip_idle", 136'(s_busy), 136'(0));
        check_output("skip_novalid", 136'(n_valid), 136'(0));

        send_frame(make_cmd(6'd2, 32'h0), 48);
        check_req("cmd2", 1'b0, 6'd2, 32'h0);
        respond(0, 1'b0, 1'b1, 6'd0, 120'h1, -1, "r2");

        div = 3;
        send_frame(make_cmd(6'd17, 32'h1234), 48);
        check_req("cmd17", 1'b0, 6'd17, 32'h1234);
        respond(5, 1'b0, 1'b0, 6'd17, 120'hCAFEBABE, -1, "late");

        send_frame(make_cmd(6'd13, 32'h10000), 48);
        check_req("cmd13", 1'b0, 6'd13, 32'h10000);
        respond(1, 1'b1, 1'b0, 6'd13, 120'h900, -1, "samecyc");

        div = 2;
        send_frame(make_cmd(6'd7, 32'hABCD0000), 48);
        check_req("cmd7", 1'b0, 6'd7, 32'hABCD0000);
        strobe(1'b1);
        send_frame(48'h400000000095, 48);
        check_output("abandon_ready", 136'(first_ready), 136'(0));
        check_req("abandon_cmd0", 1'b0, 6'd0, 32'h0);

        div = 1;
        send_frame(48'h770000000065, 48);
        check_req("cmd55a", 1'b0, 6'd55, 32'h0);
        send_frame(48'h770000000065, 20);
        reset_check("rst_rx");
        send_frame(48'h770000000065, 48);
        check_req("cmd55b", 1'b0, 6'd55, 32'h0);

        send_frame(48'h48000001AA87, 48);
        check_req("cmd8b", 1'b0, 6'd8, 32'h1AA);
        respond(0, 1'b0, 1'b0, 6'd8, 120'h1AA, 30, "abort");
        check_output("abort_driving", 136'(s_en), 136'(1));
        reset_check("rst_tx");
        send_frame(48'h770000000065, 48);
        check_req("cmd55c", 1'b0, 6'd55, 32'h0);

        for (int t = 0; t < 10; t++) begin
            div  = $urandom_range(1, 3);
            rid  = 6'($urandom_range(0, 63));
            rarg = $urandom;
            rf   = make_cmd(rid, rarg);
            flaw = $urandom_range(0, 3);
            if (flaw == 2) begin
                idx = $urandom_range(1, 7);
                rf[idx] = ~rf[idx];
            end else if (flaw == 3) begin
                rf[0] = 1'b0;
            end
            send_frame(rf, 48);
            check_req("rnd_req", flaw >= 2, rid, rarg);
            if (flaw < 2) begin
                rdata = 120'({$urandom, $urandom, $urandom, $urandom});
                respond($urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        6'($urandom), rdata, -1, "rnd_rsp");
            end else begin
                idle_probe(4, "rnd_bad");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog timeout after %0d checks", checks);
        $fatal(1, "[TB] simulation did not complete");
    end
endmodule
